// File: rtl/ddr2pe_config.sv
// ddr2pe_config: decodes DDR->PE load instructions, programs the DDR read
// engines (ddr1 = image, ddr2 = weight/bias) and the PE-buffer scatter unit,
// then blocks the next instruction until every started engine reports done.
//
// Handshake: an instruction is taken on a rising edge where
// i_ins_valid && o_ins_ready; i_ins must be stable while i_ins_valid is high.
// The engines are fire-and-forget: a one-cycle start pulse, then a one-cycle
// done pulse whenever the engine finishes (possibly in the start cycle).
module ddr2pe_config #(
  parameter int PE_NUM     = 32,
  parameter int INST_W     = 64,
  parameter int DDR_ADDR_W = 32,
  parameter int BURST_W    = 16,
  localparam int PE_W      = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_layer_type,
  input  logic [3:0]            i_in_ch_seg,
  input  logic [7:0]            i_img_width,
  input  logic [INST_W-1:0]     i_ins,
  input  logic                  i_ins_valid,
  output logic                  o_ins_ready,
  output logic                  o_ins_done,
  output logic                  o_ddr1_start,
  output logic [DDR_ADDR_W-1:0] o_ddr1_st_addr,
  output logic [DDR_ADDR_W-1:0] o_ddr1_step,
  output logic [BURST_W-1:0]    o_ddr1_burst,
  output logic [BURST_W-1:0]    o_ddr1_burst_num,
  input  logic                  i_ddr1_done,
  output logic                  o_ddr2_start,
  output logic [DDR_ADDR_W-1:0] o_ddr2_st_addr,
  output logic [DDR_ADDR_W-1:0] o_ddr2_step,
  output logic [BURST_W-1:0]    o_ddr2_burst,
  output logic [BURST_W-1:0]    o_ddr2_burst_num,
  input  logic                  i_ddr2_done,
  output logic                  o_sc_start,
  output logic [1:0]            o_sc_conf_mode,
  output logic [3:0]            o_sc_conf_pix_num,
  output logic [3:0]            o_sc_conf_row_num,
  output logic [PE_W-1:0]       o_sc_conf_pe_sel,
  input  logic                  i_sc_done,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WORK  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;

  logic                  r_ins_ready;
  logic                  r_ins_done;
  logic                  r_ddr1_start;
  logic                  r_ddr2_start;
  logic                  r_sc_start;
  logic [DDR_ADDR_W-1:0] r_ddr1_st_addr;
  logic [DDR_ADDR_W-1:0] r_ddr1_step;
  logic [BURST_W-1:0]    r_ddr1_burst;
  logic [BURST_W-1:0]    r_ddr1_burst_num;
  logic [DDR_ADDR_W-1:0] r_ddr2_st_addr;
  logic [DDR_ADDR_W-1:0] r_ddr2_step;
  logic [BURST_W-1:0]    r_ddr2_burst;
  logic [BURST_W-1:0]    r_ddr2_burst_num;
  logic [1:0]            r_sc_mode;
  logic [3:0]            r_sc_pix_num;
  logic [3:0]            r_sc_row_num;
  logic [PE_W-1:0]       r_sc_pe_sel;

  // Which read engine the current op started, and the sticky done flags.
  logic r_op_img;
  logic r_ddr1_seen;
  logic r_ddr2_seen;
  logic r_sc_seen;

  // Instruction fields
  logic [3:0] w_opcode;
  logic [5:0] w_buf_id;
  logic [3:0] w_row_num;
  logic [3:0] w_pix_num;
  logic [7:0] w_size;
  logic       w_is_img;
  logic       w_is_wgt;
  logic       w_is_bias;
  logic       w_legal;
  logic       w_accept;

  assign w_opcode  = i_ins[61:58];
  assign w_buf_id  = i_ins[57:52];
  assign w_row_num = i_ins[47:44];
  assign w_pix_num = i_ins[43:40];
  assign w_size    = i_ins[47:40];

  assign w_is_img  = (w_opcode == 4'b0001);
  assign w_is_wgt  = (w_opcode == 4'b0010);
  assign w_is_bias = (w_opcode == 4'b0100);
  assign w_legal   = w_is_img | w_is_wgt | w_is_bias;
  assign w_accept  = i_ins_valid & r_ins_ready;

  // Derived configuration. Arithmetic is done modulo the port width, which
  // equals computing at full width and truncating.
  logic [BURST_W-1:0]    w_ddr1_burst;
  logic [DDR_ADDR_W-1:0] w_ddr1_step;
  logic [BURST_W-1:0]    w_ddr1_burst_num;
  logic [BURST_W-1:0]    w_size_p1;
  logic [5:0]            w_pe_full;
  logic [DDR_ADDR_W-1:0] w_st_addr;

  assign w_ddr1_burst     = ((BURST_W'(w_pix_num) + BURST_W'(1)) *
                             BURST_W'(i_in_ch_seg)) << 5;
  assign w_ddr1_step      = ((DDR_ADDR_W'(w_pix_num) + DDR_ADDR_W'(1)) *
                             DDR_ADDR_W'(i_img_width)) << 5;
  assign w_ddr1_burst_num = BURST_W'(w_row_num) + BURST_W'(1);
  assign w_size_p1        = BURST_W'(w_size) + BURST_W'(1);
  assign w_pe_full        = i_layer_type[0] ? (w_buf_id >> 2) : w_buf_id;
  assign w_st_addr        = DDR_ADDR_W'(i_ins[31:0]);

  // Done flags including this cycle's pulses; only started engines count.
  logic w_ddr1_seen_nxt;
  logic w_ddr2_seen_nxt;
  logic w_sc_seen_nxt;
  logic w_all_done;

  assign w_ddr1_seen_nxt = r_ddr1_seen | (i_ddr1_done & r_op_img);
  assign w_ddr2_seen_nxt = r_ddr2_seen | (i_ddr2_done & ~r_op_img);
  assign w_sc_seen_nxt   = r_sc_seen | i_sc_done;
  assign w_all_done      = w_sc_seen_nxt &
                           (r_op_img ? w_ddr1_seen_nxt : w_ddr2_seen_nxt);

  // Sequencer FSM with registered handshake, start pulses and configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_IDLE;
      r_ins_ready      <= 1'b1;
      r_ins_done       <= 1'b0;
      r_ddr1_start     <= 1'b0;
      r_ddr2_start     <= 1'b0;
      r_sc_start       <= 1'b0;
      r_ddr1_st_addr   <= '0;
      r_ddr1_step      <= '0;
      r_ddr1_burst     <= '0;
      r_ddr1_burst_num <= '0;
      r_ddr2_st_addr   <= '0;
      r_ddr2_step      <= '0;
      r_ddr2_burst     <= '0;
      r_ddr2_burst_num <= '0;
      r_sc_mode        <= '0;
      r_sc_pix_num     <= '0;
      r_sc_row_num     <= '0;
      r_sc_pe_sel      <= '0;
      r_op_img         <= 1'b0;
      r_ddr1_seen      <= 1'b0;
      r_ddr2_seen      <= 1'b0;
      r_sc_seen        <= 1'b0;
    end else begin
      r_ins_done   <= 1'b0;
      r_ddr1_start <= 1'b0;
      r_ddr2_start <= 1'b0;
      r_sc_start   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ins_ready <= 1'b0;
            r_ddr1_seen <= 1'b0;
            r_ddr2_seen <= 1'b0;
            r_sc_seen   <= 1'b0;
            if (w_legal) begin
              r_state      <= S_START;
              r_op_img     <= w_is_img;
              r_sc_start   <= 1'b1;
              r_sc_pe_sel  <= PE_W'(w_pe_full);
              if (w_is_img) begin
                r_ddr1_start     <= 1'b1;
                r_ddr1_st_addr   <= w_st_addr;
                r_ddr1_burst     <= w_ddr1_burst;
                r_ddr1_step      <= w_ddr1_step;
                r_ddr1_burst_num <= w_ddr1_burst_num;
                r_sc_mode        <= 2'd0;
                r_sc_pix_num     <= w_pix_num;
                r_sc_row_num     <= w_row_num;
              end else begin
                r_ddr2_start     <= 1'b1;
                r_ddr2_st_addr   <= w_st_addr;
                r_ddr2_burst     <= w_is_wgt ? (w_size_p1 << 5) : w_size_p1;
                r_ddr2_step      <= '0;
                r_ddr2_burst_num <= BURST_W'(1);
                r_sc_mode        <= w_is_wgt ? 2'd1 : 2'd2;
                r_sc_pix_num     <= 4'd0;
                r_sc_row_num     <= 4'd0;
              end
            end else begin
              r_state    <= S_DONE;
              r_ins_done <= 1'b1;
            end
          end
        end
        S_START: begin
          r_ddr1_seen <= w_ddr1_seen_nxt;
          r_ddr2_seen <= w_ddr2_seen_nxt;
          r_sc_seen   <= w_sc_seen_nxt;
          r_state     <= S_WORK;
        end
        S_WORK: begin
          r_ddr1_seen <= w_ddr1_seen_nxt;
          r_ddr2_seen <= w_ddr2_seen_nxt;
          r_sc_seen   <= w_sc_seen_nxt;
          if (w_all_done) begin
            r_state     <= S_IDLE;
            r_ins_ready <= 1'b1;
            r_ins_done  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_ins_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ins_ready       = r_ins_ready;
  assign o_ins_done        = r_ins_done;
  assign o_ddr1_start      = r_ddr1_start;
  assign o_ddr1_st_addr    = r_ddr1_st_addr;
  assign o_ddr1_step       = r_ddr1_step;
  assign o_ddr1_burst      = r_ddr1_burst;
  assign o_ddr1_burst_num  = r_ddr1_burst_num;
  assign o_ddr2_start      = r_ddr2_start;
  assign o_ddr2_st_addr    = r_ddr2_st_addr;
  assign o_ddr2_step       = r_ddr2_step;
  assign o_ddr2_burst      = r_ddr2_burst;
  assign o_ddr2_burst_num  = r_ddr2_burst_num;
  assign o_sc_start        = r_sc_start;
  assign o_sc_conf_mode    = r_sc_mode;
  assign o_sc_conf_pix_num = r_sc_pix_num;
  assign o_sc_conf_row_num = r_sc_row_num;
  assign o_sc_conf_pe_sel  = r_sc_pe_sel;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_ddr2pe_config.sv
// Bench for ddr2pe_config: a table of load instructions with hand-computed
// configuration, randomized done timing, plus hand-written corner sequences.
module tb_ddr2pe_config;

  localparam int W = 114;

  logic        clk;
  logic        rst;
  logic [3:0]  i_layer_type;
  logic [3:0]  i_in_ch_seg;
  logic [7:0]  i_img_width;
  logic [63:0] i_ins;
  logic        i_ins_valid;
  logic        o_ins_ready;
  logic        o_ins_done;
  logic        o_ddr1_start;
  logic [31:0] o_ddr1_st_addr;
  logic [31:0] o_ddr1_step;
  logic [15:0] o_ddr1_burst;
  logic [15:0] o_ddr1_burst_num;
  logic        i_ddr1_done;
  logic        o_ddr2_start;
  logic [31:0] o_ddr2_st_addr;
  logic [31:0] o_ddr2_step;
  logic [15:0] o_ddr2_burst;
  logic [15:0] o_ddr2_burst_num;
  logic        i_ddr2_done;
  logic        o_sc_start;
  logic [1:0]  o_sc_conf_mode;
  logic [3:0]  o_sc_conf_pix_num;
  logic [3:0]  o_sc_conf_row_num;
  logic [4:0]  o_sc_conf_pe_sel;
  logic        i_sc_done;
  logic [1:0]  o_dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  ddr2pe_config dut (
    .clk(clk), .rst(rst),
    .i_layer_type(i_layer_type), .i_in_ch_seg(i_in_ch_seg),
    .i_img_width(i_img_width), .i_ins(i_ins), .i_ins_valid(i_ins_valid),
    .o_ins_ready(o_ins_ready), .o_ins_done(o_ins_done),
    .o_ddr1_start(o_ddr1_start), .o_ddr1_st_addr(o_ddr1_st_addr),
    .o_ddr1_step(o_ddr1_step), .o_ddr1_burst(o_ddr1_burst),
    .o_ddr1_burst_num(o_ddr1_burst_num), .i_ddr1_done(i_ddr1_done),
    .o_ddr2_start(o_ddr2_start), .o_ddr2_st_addr(o_ddr2_st_addr),
    .o_ddr2_step(o_ddr2_step), .o_ddr2_burst(o_ddr2_burst),
    .o_ddr2_burst_num(o_ddr2_burst_num), .i_ddr2_done(i_ddr2_done),
    .o_sc_start(o_sc_start), .o_sc_conf_mode(o_sc_conf_mode),
    .o_sc_conf_pix_num(o_sc_conf_pix_num), .o_sc_conf_row_num(o_sc_conf_row_num),
    .o_sc_conf_pe_sel(o_sc_conf_pe_sel), .i_sc_done(i_sc_done),
    .o_dbg_state(o_dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  buf_id;
    logic [7:0]  size;
    logic [31:0] addr;
    logic [3:0]  lt;
    logic [3:0]  seg;
    logic [7:0]  width;
    logic [15:0] e_burst;
    logic [31:0] e_step;
    logic [15:0] e_bnum;
    logic [1:0]  e_mode;
    logic [3:0]  e_pix;
    logic [3:0]  e_row;
    logic [4:0]  e_pe;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk_ins(input logic [3:0] op, input logic [5:0] b,
                                         input logic [7:0] sz, input logic [31:0] a);
    logic [1:0] j0;
    logic [3:0] j1;
    logic [7:0] j2;
    j0 = 2'($urandom);
    j1 = 4'($urandom);
    j2 = 8'($urandom);
    return {j0, op, b, j1, sz, j2, a};
  endfunction

  // Waits (bounded) for ready, then presents ins for exactly one accept edge.
  task automatic accept_ins(input logic [63:0] ins);
    int g;
    g = 0;
    while (!o_ins_ready && g < 50) begin
      tick();
      g++;
    end
    if (g == 50) check("ready_timeout", 128'(o_ins_ready), 128'd1);
    i_ins = ins;
    i_ins_valid = 1'b1;
    tick();
    i_ins_valid = 1'b0;
  endtask

  // One legal op: da = cycle of the required ddr done, db = cycle of sc_done,
  // sp = cycle of a done pulse from the engine that was not started.
  task automatic run_op(input vec_t v, input int da, input int db, input int sp);
    logic [W-1:0] e;
    logic [W-1:0] a;
    logic         img;
    int           ex;
    img = (v.op == 4'b0001);
    ex = (da > db) ? da : db;
    if (ex < 2) ex = 2;
    ex = ex + 1;
    i_layer_type = v.lt;
    i_in_ch_seg = v.seg;
    i_img_width = v.width;
    e = {img, ~img, 1'b1, v.addr, v.e_burst, v.e_step, v.e_bnum,
         v.e_mode, v.e_pix, v.e_row, v.e_pe};
    exp_q.push_back(e);
    accept_ins(mk_ins(v.op, v.buf_id, v.size, v.addr));
    if (img)
      a = {o_ddr1_start, o_ddr2_start, o_sc_start, o_ddr1_st_addr, o_ddr1_burst,
           o_ddr1_step, o_ddr1_burst_num, o_sc_conf_mode, o_sc_conf_pix_num,
           o_sc_conf_row_num, o_sc_conf_pe_sel};
    else
      a = {o_ddr1_start, o_ddr2_start, o_sc_start, o_ddr2_st_addr, o_ddr2_burst,
           o_ddr2_step, o_ddr2_burst_num, o_sc_conf_mode, o_sc_conf_pix_num,
           o_sc_conf_row_num, o_sc_conf_pe_sel};
    check("conf", 128'(a), 128'(exp_q.pop_front()));
    for (int k = 1; k <= ex; k++) begin
      check("ins_done", 128'(o_ins_done), 128'(k == ex));
      check("ins_ready", 128'(o_ins_ready), 128'(k == ex));
      if (k > 1)
        check("no_restart", 128'({o_ddr1_start, o_ddr2_start, o_sc_start}), 128'd0);
      if (k < ex) begin
        i_ddr1_done = img ? (k == da) : (k == sp);
        i_ddr2_done = img ? (k == sp) : (k == da);
        i_sc_done = (k == db);
        tick();
        i_ddr1_done = 1'b0;
        i_ddr2_done = 1'b0;
        i_sc_done = 1'b0;
      end
    end
    tick();
    check("done_pulse_end", 128'({o_ins_done, o_ins_ready}), 128'b01);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 6'd5,  8'h23, 32'h0000_1000, 4'd0, 4'd2,  8'd8,
                16'd256,  32'd1024,   16'd3,  2'd0, 4'd3,  4'd2,  5'd5};
    vecs[1] = '{4'b0010, 6'd45, 8'h07, 32'h2000_0040, 4'd1, 4'd3,  8'd9,
                16'd256,  32'd0,      16'd1,  2'd1, 4'd0,  4'd0,  5'd11};
    vecs[2] = '{4'b0100, 6'd63, 8'h07, 32'hdead_beef, 4'd0, 4'd1,  8'd2,
                16'd8,    32'd0,      16'd1,  2'd2, 4'd0,  4'd0,  5'd31};
    vecs[3] = '{4'b0001, 6'd33, 8'hff, 32'hffff_fff0, 4'd3, 4'd15, 8'd255,
                16'd7680, 32'd130560, 16'd16, 2'd0, 4'd15, 4'd15, 5'd8};
    vecs[4] = '{4'b0010, 6'd32, 8'hff, 32'h0000_0000, 4'd0, 4'd0,  8'd0,
                16'd8192, 32'd0,      16'd1,  2'd1, 4'd0,  4'd0,  5'd0};
    vecs[5] = '{4'b0100, 6'd3,  8'h00, 32'h0000_0004, 4'd1, 4'd0,  8'd0,
                16'd1,    32'd0,      16'd1,  2'd2, 4'd0,  4'd0,  5'd0};
    vecs[6] = '{4'b0001, 6'd1,  8'h00, 32'h0000_0080, 4'd0, 4'd0,  8'd1,
                16'd0,    32'd32,     16'd1,  2'd0, 4'd0,  4'd0,  5'd1};

    // Reset
    rst = 1'b1;
    i_layer_type = '0; i_in_ch_seg = '0; i_img_width = '0;
    i_ins = '0; i_ins_valid = 1'b0;
    i_ddr1_done = 1'b0; i_ddr2_done = 1'b0; i_sc_done = 1'b0;
    repeat (3) tick();
    check("rst_ready_done", 128'({o_ins_ready, o_ins_done}), 128'b10);
    check("rst_starts", 128'({o_ddr1_start, o_ddr2_start, o_sc_start}), 128'd0);
    check("rst_conf", 128'({o_ddr1_st_addr, o_ddr1_burst, o_ddr2_burst,
                            o_sc_conf_mode, o_sc_conf_pe_sel}), 128'd0);
    check("rst_state", 128'(o_dbg_state), 128'd0);
    rst = 1'b0;
    tick();

    // Table of instructions with random done timing
    for (int i = 0; i < 7; i++)
      run_op(vecs[i], $urandom_range(1, 6), $urandom_range(1, 6),
             $urandom_range(1, 7));

    // Weight: ddr2_done at T+5, sc_done at T+9, spurious ddr1_done at T+3
    run_op(vecs[1], 5, 9, 3);
    // Bias: both dones in START
    run_op(vecs[2], 1, 1, 0);

    // Dones while idle are ignored
    i_ddr1_done = 1'b1; i_ddr2_done = 1'b1; i_sc_done = 1'b1;
    tick();
    i_ddr1_done = 1'b0; i_ddr2_done = 1'b0; i_sc_done = 1'b0;
    check("idle_dones", 128'({o_dbg_state, o_ins_ready, o_ins_done, o_ddr1_start,
                              o_ddr2_start, o_sc_start}), 128'b00_1_0_000);
    tick();

    // NOPs back to back (1111 then 0011)
    i_ins = mk_ins(4'b1111, 6'd7, 8'h11, 32'h1234);
    i_ins_valid = 1'b1;
    tick();
    check("nop1_t1", 128'({o_ins_done, o_ins_ready, o_ddr1_start, o_ddr2_start,
                           o_sc_start}), 128'b10_000);
    i_ins = mk_ins(4'b0011, 6'd7, 8'h11, 32'h1234);
    tick();
    check("nop1_t2", 128'({o_ins_done, o_ins_ready}), 128'b01);
    tick();
    i_ins_valid = 1'b0;
    check("nop2_t1", 128'({o_ins_done, o_ins_ready, o_ddr1_start, o_ddr2_start,
                           o_sc_start}), 128'b10_000);
    tick();
    check("nop2_t2", 128'({o_ins_done, o_ins_ready}), 128'b01);

    // Reset in WORK with a stale sc flag, then an image op that must still
    // wait for its own sc_done
    i_layer_type = 4'd0;
    accept_ins(mk_ins(4'b0010, 6'd2, 8'h07, 32'h40));
    check("pre_rst_start", 128'({o_ddr2_start, o_sc_start}), 128'b11);
    i_sc_done = 1'b1;
    tick();
    i_sc_done = 1'b0;
    check("pre_rst_work", 128'(o_dbg_state), 128'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst", 128'({o_ins_ready, o_ins_done, o_ddr1_start, o_ddr2_start,
                           o_sc_start}), 128'b10_000);
    check("mid_rst_conf", 128'({o_ddr2_burst, o_ddr2_st_addr, o_dbg_state}), 128'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_quiet", 128'({o_ins_done, o_ins_ready}), 128'b01);
    end
    run_op(vecs[0], 3, 6, 2);

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
